// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle shared by the register-bank slave and whatever master drives it.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers; read-only ones return reg_in.
// Misses and writes to read-only registers complete with SLVERR.
module axi4_lite_reg_slave #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [63:0] RO_MASK   = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    axi4_lite_if.slave             bus,
    output logic [NUM_REGS*32-1:0] reg_out,
    input  logic [NUM_REGS*32-1:0] reg_in,
    output logic [NUM_REGS-1:0]    wr_pulse
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_VALID} rstate_t;

    wstate_t w_state, w_state_next;
    rstate_t r_state, r_state_next;

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d, status;
    logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
    logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [31:0]               awaddr_q, wdata_q;
    logic [3:0]                wstrb_q;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic                      arready_q, arready_d;
    logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]               rdata_q, rdata_d;

    logic                      aw_hs, w_hs, ar_hs, wr_exec;
    logic [31:0]               wr_addr, wr_data, wr_off, rd_off;
    logic [3:0]                wr_strb;
    logic                      wr_hit, rd_hit;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      unused_bits;

    assign status = reg_in;

    assign aw_hs = bus.awvalid && awready_q;
    assign w_hs  = bus.wvalid && wready_q;
    assign ar_hs = bus.arvalid && arready_q;

    // A channel arriving this cycle counts as held, so same-cycle AW+W executes at once.
    assign wr_exec = (w_state == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : bus.awaddr;
    assign wr_data = w_held_q ? wdata_q : bus.wdata;
    assign wr_strb = w_held_q ? wstrb_q : bus.wstrb;

    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_hit = (wr_addr >= BASE_ADDR) && ({2'b00, wr_off[31:2]} < NUM_REGS);
    assign wr_idx = wr_off[IDX_W+1:2];

    assign rd_off = bus.araddr - BASE_ADDR;
    assign rd_hit = (bus.araddr >= BASE_ADDR) && ({2'b00, rd_off[31:2]} < NUM_REGS);
    assign rd_idx = rd_off[IDX_W+1:2];

    assign unused_bits = ^{bus.awprot, bus.arprot, wr_off[1:0], rd_off[1:0]};

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
        end else begin
            w_state    <= w_state_next;
            r_state    <= r_state_next;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            if (aw_hs) begin
                awaddr_q <= bus.awaddr;
            end
            if (w_hs) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
        end
    end

    // Write FSM next state: collect AW/W, then hold the response until bready.
    always_comb begin
        w_state_next = w_state;
        unique case (w_state)
            W_IDLE:  if (wr_exec) w_state_next = W_RESP;
            W_RESP:  if (bus.bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write FSM outputs: holding flags, ready registers, register merge and response.
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if ((w_state == W_RESP) && bus.bready) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        awready_d = !aw_held_d && (w_state_next == W_IDLE);
        wready_d  = !w_held_d && (w_state_next == W_IDLE);

        regs_d     = regs_q;
        wr_pulse_d = '0;
        bresp_d    = bresp_q;
        if (wr_exec) begin
            if (wr_hit && !RO_MASK[wr_idx]) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
                wr_pulse_d[wr_idx] = 1'b1;
                bresp_d            = 2'b00;
            end else begin
                bresp_d = 2'b10;
            end
        end
    end

    // Read FSM next state: one outstanding read, held until rready.
    always_comb begin
        r_state_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_VALID;
            R_VALID: if (bus.rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM outputs: sample data at the handshake (pre-write value on a same-cycle write).
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            if (!rd_hit) begin
                rdata_d = '0;
                rresp_d = 2'b10;
            end else begin
                rdata_d = RO_MASK[rd_idx] ? status[rd_idx] : regs_q[rd_idx];
                rresp_d = 2'b00;
            end
        end
        arready_d = (r_state_next == R_IDLE);
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = (r_state == R_VALID);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign reg_out     = regs_q;
    assign wr_pulse    = wr_pulse_q;
endmodule
